// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, field ranges and TX FSM encoding.
// The router imports this package too, so field positions live only here.
package noc_pkg;
  localparam int FLIT_W   = 34;
  localparam int HEAD_BIT = 33;
  localparam int TAIL_BIT = 32;
  localparam int SRC_HI   = 31;
  localparam int SRC_LO   = 28;
  localparam int DST_HI   = 27;
  localparam int DST_LO   = 24;
  localparam int LEN_HI   = 3;
  localparam int LEN_LO   = 0;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HEAD = 2'd1,
    TX_BODY = 2'd2
  } tx_state_t;

  // A zero-length packet is a single flit, so its head is also the tail.
  function automatic flit_t make_head(input logic [3:0] src, input logic [3:0] dst,
                                      input logic [3:0] len);
    flit_t f;
    f                 = '0;
    f[HEAD_BIT]       = 1'b1;
    f[TAIL_BIT]       = (len == 4'd0);
    f[SRC_HI:SRC_LO]  = src;
    f[DST_HI:DST_LO]  = dst;
    f[LEN_HI:LEN_LO]  = len;
    return f;
  endfunction
endpackage

// File: rtl/noc_ni_if.sv
// Core-side and router-side signals of the network interface.
// Every channel is valid/ready (req/ack): a transfer happens on a rising edge
// where both are 1, and the sender holds its payload and valid/req until then.
interface noc_ni_if;
  import noc_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dst;
  logic [3:0]  cmd_len;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  flit_t       out_flit;
  logic        out_req;
  logic        in_ack;
  flit_t       in_flit;
  logic        in_req;
  logic        out_ack;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        rx_head;
  logic        rx_tail;
  logic        rx_err;
  logic [15:0] tx_pkt_cnt;
  logic [15:0] rx_pkt_cnt;
  tx_state_t   tx_state;

  modport slave (
    input  cmd_valid, cmd_dst, cmd_len, tx_valid, tx_data, in_ack,
           in_flit, in_req, rx_ready,
    output cmd_ready, tx_ready, out_flit, out_req, out_ack, rx_valid,
           rx_data, rx_head, rx_tail, rx_err, tx_pkt_cnt, rx_pkt_cnt, tx_state
  );

  modport master (
    output cmd_valid, cmd_dst, cmd_len, tx_valid, tx_data, in_ack,
           in_flit, in_req, rx_ready,
    input  cmd_ready, tx_ready, out_flit, out_req, out_ack, rx_valid,
           rx_data, rx_head, rx_tail, rx_err, tx_pkt_cnt, rx_pkt_cnt, tx_state
  );
endinterface

// File: rtl/noc_fifo.sv
// Synchronous FIFO with occupancy counter; DEPTH must be a power of two.
module noc_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/noc_ni.sv
// Network interface: packetises core commands/words into flits towards the router
// and filters/queues flits from the router for the core.
module noc_ni
  import noc_pkg::*;
#(
  parameter int ID       = 0,
  parameter int RX_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  noc_ni_if.slave ni
);
  localparam logic [3:0] MY_ID = 4'(ID);

  tx_state_t   state, state_nx;
  flit_t       flit_q, flit_nx;
  logic        req_q, req_nx;
  logic [3:0]  rem_q, rem_nx;
  logic [15:0] tx_cnt_q, tx_cnt_nx;
  logic        xfer, tx_rdy, load;

  // HEAD also accepts a word so the first body flit follows the head back to back.
  always_comb begin
    state_nx  = state;
    flit_nx   = flit_q;
    req_nx    = req_q;
    rem_nx    = rem_q;
    tx_cnt_nx = tx_cnt_q;
    xfer      = req_q && ni.in_ack;
    tx_rdy    = (state != TX_IDLE) && (rem_q != 4'd0) && (!req_q || ni.in_ack);
    load      = tx_rdy && ni.tx_valid;
    case (state)
      TX_IDLE: begin
        if (ni.cmd_valid) begin
          state_nx = TX_HEAD;
          flit_nx  = make_head(MY_ID, ni.cmd_dst, ni.cmd_len);
          req_nx   = 1'b1;
          rem_nx   = ni.cmd_len;
        end
      end
      default: begin
        if (load) begin
          flit_nx  = {1'b0, rem_q == 4'd1, ni.tx_data};
          req_nx   = 1'b1;
          rem_nx   = rem_q - 4'd1;
          state_nx = TX_BODY;
        end else if (xfer) begin
          req_nx = 1'b0;
          if (flit_q[TAIL_BIT]) begin
            state_nx  = TX_IDLE;
            tx_cnt_nx = tx_cnt_q + 16'd1;
          end else begin
            state_nx = TX_BODY;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      flit_q   <= '0;
      req_q    <= 1'b0;
      rem_q    <= '0;
      tx_cnt_q <= '0;
    end else begin
      state    <= state_nx;
      flit_q   <= flit_nx;
      req_q    <= req_nx;
      rem_q    <= rem_nx;
      tx_cnt_q <= tx_cnt_nx;
    end
  end

  assign ni.cmd_ready  = (state == TX_IDLE);
  assign ni.tx_ready   = tx_rdy;
  assign ni.out_flit   = flit_q;
  assign ni.out_req    = req_q;
  assign ni.tx_pkt_cnt = tx_cnt_q;
  assign ni.tx_state   = state;

  logic        full, empty, accept, push;
  logic        in_pkt_q, in_pkt_nx, drop_q, drop_nx, err_nx, err_q;
  logic [15:0] rx_cnt_q, rx_cnt_nx;
  flit_t       head_flit;

  // Foreign packets and stray body flits are still acked so the router never stalls on them.
  assign accept = ni.in_req && !full;

  always_comb begin
    push      = 1'b0;
    err_nx    = 1'b0;
    in_pkt_nx = in_pkt_q;
    drop_nx   = drop_q;
    rx_cnt_nx = rx_cnt_q;
    if (accept) begin
      if (ni.in_flit[HEAD_BIT]) begin
        if (ni.in_flit[DST_HI:DST_LO] == MY_ID) begin
          push      = 1'b1;
          drop_nx   = 1'b0;
          in_pkt_nx = !ni.in_flit[TAIL_BIT];
          if (ni.in_flit[TAIL_BIT]) rx_cnt_nx = rx_cnt_q + 16'd1;
        end else begin
          err_nx    = 1'b1;
          in_pkt_nx = 1'b0;
          drop_nx   = !ni.in_flit[TAIL_BIT];
        end
      end else if (drop_q) begin
        if (ni.in_flit[TAIL_BIT]) drop_nx = 1'b0;
      end else if (in_pkt_q) begin
        push = 1'b1;
        if (ni.in_flit[TAIL_BIT]) begin
          in_pkt_nx = 1'b0;
          rx_cnt_nx = rx_cnt_q + 16'd1;
        end
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt_q <= 1'b0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
      rx_cnt_q <= '0;
    end else begin
      in_pkt_q <= in_pkt_nx;
      drop_q   <= drop_nx;
      err_q    <= err_nx;
      rx_cnt_q <= rx_cnt_nx;
    end
  end

  noc_fifo #(.WIDTH(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (ni.rx_valid && ni.rx_ready),
    .din   (ni.in_flit),
    .dout  (head_flit),
    .full  (full),
    .empty (empty)
  );

  assign ni.out_ack    = !full;
  assign ni.rx_valid   = !empty;
  assign ni.rx_data    = head_flit[31:0];
  assign ni.rx_head    = head_flit[HEAD_BIT];
  assign ni.rx_tail    = head_flit[TAIL_BIT];
  assign ni.rx_err     = err_q;
  assign ni.rx_pkt_cnt = rx_cnt_q;
endmodule

// File: tb/tb_noc_ni.sv
// Bench for noc_ni at ID=5, RX_DEPTH=4: table-driven TX/RX packets with
// scoreboard queues, plus hand sequences for stall, FIFO-full and async reset.
module tb_noc_ni;
  import noc_pkg::*;

  localparam int         ID       = 5;
  localparam int         RX_DEPTH = 4;
  localparam logic [3:0] MY_ID    = 4'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  noc_ni_if ni();

  noc_ni #(.ID(ID), .RX_DEPTH(RX_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .ni  (ni.slave)
  );

  always #5 clk = ~clk;

  int      vecs = 0;
  int      fails = 0;
  longint  cyc = 0;
  longint  last_cyc = 0;
  bit      chk_consec = 0;
  int      ack_mode = 0, rdy_mode = 0;
  logic    ack_force = 1'b0, ack_gen = 1'b1;
  logic    rdy_force = 1'b0, rdy_gen = 1'b1;
  int      err_seen = 0, exp_err = 0, tx_pkts = 0, rx_pkts = 0;
  logic [33:0] tx_exp_q[$];
  logic [33:0] rx_exp_q[$];
  logic [33:0] snap;
  logic [33:0] f5[5];

  typedef struct { logic [3:0] dst; logic [3:0] len; int ack_mode; } tx_vec_t;
  typedef struct { logic [3:0] dst; int nbody; int rdy_mode; bit stray; } rx_vec_t;
  tx_vec_t tx_tab[6];
  rx_vec_t rx_tab[7];

  assign ni.in_ack   = (ack_mode == 2) ? ack_force : ack_gen;
  assign ni.rx_ready = (rdy_mode == 2) ? rdy_force : rdy_gen;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    ack_gen = (ack_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    rdy_gen = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vecs++;
    fails++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // TX scoreboard: every flit crossing out_req/in_ack must be the next expected one.
  always @(negedge clk) begin
    if (!rst && ni.out_req && ni.in_ack) begin
      if (tx_exp_q.size() == 0) begin
        vecs++;
        fails++;
        $display("FAIL tx_extra: got %0h expected none", ni.out_flit);
      end else begin
        check("tx_flit", 64'(ni.out_flit), 64'(tx_exp_q.pop_front()));
      end
      if (chk_consec && !ni.out_flit[HEAD_BIT]) check("tx_gap", 64'(cyc - last_cyc), 64'd1);
      last_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ni.rx_err) err_seen++;
      if (ni.rx_valid && ni.rx_ready) begin
        if (rx_exp_q.size() == 0) begin
          vecs++;
          fails++;
          $display("FAIL rx_extra: got %0h expected none", {ni.rx_head, ni.rx_tail, ni.rx_data});
        end else begin
          check("rx_flit", 64'({ni.rx_head, ni.rx_tail, ni.rx_data}), 64'(rx_exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_pkt(input logic [3:0] dst, input logic [3:0] len, input bit fixed);
    int n;
    logic [31:0] w;
    tx_exp_q.push_back(make_head(MY_ID, dst, len));
    @(posedge clk); #1;
    ni.cmd_valid = 1'b1;
    ni.cmd_dst   = dst;
    ni.cmd_len   = len;
    @(negedge clk); n = 0;
    while (!ni.cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("cmd_wait");
    @(posedge clk); #1;
    ni.cmd_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      w = fixed ? 32'(i + 10) : $urandom;
      ni.tx_data  = w;
      ni.tx_valid = 1'b1;
      tx_exp_q.push_back({1'b0, i == int'(len) - 1, w});
      @(negedge clk); n = 0;
      while (!ni.tx_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout("tx_word_wait");
      @(posedge clk); #1;
    end
    ni.tx_valid = 1'b0;
    @(negedge clk); n = 0;
    while (!ni.cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("tx_done_wait");
    tx_pkts++;
    check("tx_pkt_cnt", 64'(ni.tx_pkt_cnt), 64'(tx_pkts));
    check("tx_req_idle", 64'(ni.out_req), 64'd0);
  endtask

  task automatic rx_flit(input logic [33:0] f);
    int n;
    ni.in_flit = f;
    ni.in_req  = 1'b1;
    @(negedge clk); n = 0;
    while (!ni.out_ack && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("rx_ack_wait");
    @(posedge clk); #1;
    ni.in_req = 1'b0;
  endtask

  task automatic rx_pkt(input logic [3:0] dst, input int nbody);
    logic [33:0] f;
    bit keep;
    keep = (dst == MY_ID);
    f = make_head(4'($urandom_range(0, 15)), dst, 4'(nbody));
    if (keep) rx_exp_q.push_back(f); else exp_err++;
    rx_flit(f);
    for (int i = 0; i < nbody; i++) begin
      f = {1'b0, i == nbody - 1, 32'($urandom)};
      if (keep) rx_exp_q.push_back(f);
      rx_flit(f);
    end
    if (keep) rx_pkts++;
  endtask

  task automatic rx_drain_check();
    int n;
    n = 0;
    while (rx_exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout("rx_drain");
    repeat (3) @(negedge clk);
    check("rx_err_count", 64'(err_seen), 64'(exp_err));
    check("rx_pkt_cnt", 64'(ni.rx_pkt_cnt), 64'(rx_pkts));
    check("rx_valid_empty", 64'(ni.rx_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    tx_tab[0] = '{4'd9,  4'd0,  0};
    tx_tab[1] = '{4'd5,  4'd1,  1};
    tx_tab[2] = '{4'd0,  4'd15, 1};
    tx_tab[3] = '{4'd15, 4'd2,  1};
    tx_tab[4] = '{4'd7,  4'd4,  0};
    tx_tab[5] = '{4'd1,  4'd0,  1};
    rx_tab[0] = '{4'd5, 2, 1, 1'b0};
    rx_tab[1] = '{4'd7, 2, 0, 1'b0};
    rx_tab[2] = '{4'd5, 0, 1, 1'b0};
    rx_tab[3] = '{4'd3, 0, 0, 1'b0};
    rx_tab[4] = '{4'd0, 0, 0, 1'b1};
    rx_tab[5] = '{4'd5, 6, 1, 1'b0};
    rx_tab[6] = '{4'd5, 1, 0, 1'b0};

    ni.cmd_valid = 1'b0; ni.cmd_dst = '0; ni.cmd_len = '0;
    ni.tx_valid  = 1'b0; ni.tx_data = '0;
    ni.in_flit   = '0;   ni.in_req  = 1'b0;

    #12;
    check("rst_out_req",   64'(ni.out_req),    64'd0);
    check("rst_out_flit",  64'(ni.out_flit),   64'd0);
    check("rst_rx_valid",  64'(ni.rx_valid),   64'd0);
    check("rst_rx_err",    64'(ni.rx_err),     64'd0);
    check("rst_tx_ready",  64'(ni.tx_ready),   64'd0);
    check("rst_cmd_ready", 64'(ni.cmd_ready),  64'd1);
    check("rst_out_ack",   64'(ni.out_ack),    64'd1);
    check("rst_tx_cnt",    64'(ni.tx_pkt_cnt), 64'd0);
    check("rst_rx_cnt",    64'(ni.rx_pkt_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      ack_mode = tx_tab[i].ack_mode;
      send_pkt(tx_tab[i].dst, tx_tab[i].len, 1'b0);
    end
    ack_mode = 0;

    // Back-to-back words 0xA, 0xB, 0xC must leave on consecutive cycles.
    chk_consec = 1'b1;
    send_pkt(4'd2, 4'd3, 1'b1);
    chk_consec = 1'b0;

    fork
      send_pkt(4'd3, 4'd3, 1'b0);
      begin
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!(ni.out_req && !ni.out_flit[HEAD_BIT]) && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("stall_body_wait");
        ack_mode  = 2;
        ack_force = 1'b0;
        snap      = ni.out_flit;
        repeat (10) begin
          @(negedge clk);
          check("stall_flit", 64'(ni.out_flit), 64'(snap));
          check("stall_tx_ready", 64'(ni.tx_ready), 64'd0);
          check("stall_out_req", 64'(ni.out_req), 64'd1);
        end
        @(posedge clk); #1;
        ack_mode = 0;
      end
    join
    check("tx_q_drained", 64'(tx_exp_q.size()), 64'd0);

    for (int i = 0; i < 7; i++) begin
      rdy_mode = rx_tab[i].rdy_mode;
      @(posedge clk); #1;
      if (rx_tab[i].stray) begin
        exp_err++;
        rx_flit({1'b0, 1'b1, 32'($urandom)});
      end else begin
        rx_pkt(rx_tab[i].dst, rx_tab[i].nbody);
      end
      rx_drain_check();
    end

    // Five flits into a four-entry FIFO with the core not reading.
    rdy_mode  = 2;
    rdy_force = 1'b0;
    f5[0] = make_head(4'd1, MY_ID, 4'd4);
    for (int i = 1; i < 5; i++) f5[i] = {1'b0, i == 4, 32'($urandom)};
    for (int i = 0; i < 5; i++) rx_exp_q.push_back(f5[i]);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rx_flit(f5[i]);
    @(negedge clk);
    check("full_out_ack", 64'(ni.out_ack), 64'd0);
    check("full_rx_valid", 64'(ni.rx_valid), 64'd1);
    ni.in_flit = f5[4];
    ni.in_req  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_hold_ack", 64'(ni.out_ack), 64'd0);
    end
    @(posedge clk); #1;
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b0;
    @(negedge clk);
    check("after_pop_ack", 64'(ni.out_ack), 64'd1);
    @(posedge clk); #1;
    ni.in_req = 1'b0;
    @(negedge clk);
    check("refull_ack", 64'(ni.out_ack), 64'd0);
    rx_pkts++;
    rdy_mode = 0;
    rx_drain_check();

    // Asynchronous reset while a body flit is waiting for ack.
    ack_mode  = 2;
    ack_force = 1'b0;
    tx_exp_q.push_back(make_head(MY_ID, 4'd1, 4'd5));
    @(posedge clk); #1;
    ni.cmd_valid = 1'b1; ni.cmd_dst = 4'd1; ni.cmd_len = 4'd5;
    @(posedge clk); #1;
    ni.cmd_valid = 1'b0;
    ack_force    = 1'b1;
    ni.tx_data   = 32'hDEAD_BEEF;
    ni.tx_valid  = 1'b1;
    @(posedge clk); #1;
    ack_force   = 1'b0;
    ni.tx_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_state", 64'(ni.tx_state), 64'(TX_BODY));
    check("pre_rst_req", 64'(ni.out_req), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_req", 64'(ni.out_req), 64'd0);
    check("async_rst_cmd_ready", 64'(ni.cmd_ready), 64'd1);
    check("async_rst_flit", 64'(ni.out_flit), 64'd0);
    check("async_rst_tx_cnt", 64'(ni.tx_pkt_cnt), 64'd0);
    check("async_rst_rx_cnt", 64'(ni.rx_pkt_cnt), 64'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    ack_mode = 0;
    repeat (3) @(negedge clk);
    check("post_rst_req", 64'(ni.out_req), 64'd0);
    check("tx_q_final", 64'(tx_exp_q.size()), 64'd0);
    check("rx_q_final", 64'(rx_exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/noc_ni.md
NOC_NI -- requirements
Module: noc_ni

Interface
REQ-001 SHALL have parameter ID, default 0: 4-bit node id of the attached core, range 0..15.
REQ-002 SHALL have parameter RX_DEPTH, default 4: RX FIFO entries, a power of two, at least 2.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic on its rising edge.
REQ-004 rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 cmd_valid  in  1 / cmd_ready  out  1 / cmd_dst  in  4 / cmd_len  in  4  send command: destination id and payload flit count 0..15.
REQ-006 tx_valid  in  1 / tx_ready  out  1 / tx_data  in  32  core payload word stream.
REQ-007 out_flit  out  34 / out_req  out  1 / in_ack  in  1  flit channel to the router Core input.
REQ-008 in_flit  in  34 / in_req  in  1 / out_ack  out  1  flit channel from the router Core output.
REQ-009 rx_valid  out  1 / rx_ready  in  1 / rx_data  out  32 / rx_head  out  1 / rx_tail  out  1  received flit stream to the core.
REQ-010 rx_err  out  1  one-cycle pulse when a flit is dropped.
REQ-011 tx_pkt_cnt  out  16 / rx_pkt_cnt  out  16  packets sent and received.

Function
REQ-012 Flit format SHALL be: [33] head, [32] tail, [31:0] payload; head payload SHALL be [31:28] src, [27:24] dst, [23:4] zero, [3:0] len.
REQ-013 A flit SHALL transfer on each rising edge where req=1 and ack=1; on both channels, flit and req SHALL be held stable until that edge.
REQ-014 out_flit and out_req SHALL be registered.
REQ-015 TX FSM SHALL have states IDLE, HEAD, BODY; cmd_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, cmd_valid=1 SHALL cause a transition to HEAD, latch dst and len, and load out_flit = {1, len==0, ID, dst, 20'b0, len} with out_req=1 on the next cycle.
REQ-017 In HEAD on a transfer: if len=0, SHALL go to IDLE, set out_req=0 and increment tx_pkt_cnt; else SHALL go to BODY with remaining=len.
REQ-018 In BODY, tx_ready SHALL be (remaining!=0) && (!out_req || in_ack); a word handshake SHALL load out_flit = {0, remaining==1, tx_data}, set out_req=1 and decrement remaining.
REQ-019 BODY SHALL sustain one flit per cycle when in_ack is held at 1.
REQ-020 A transfer of a tail flit with no new load SHALL set out_req=0, return to IDLE and increment tx_pkt_cnt.
REQ-021 cmd_dst=ID SHALL be legal (loopback through the router).
REQ-022 The RX FIFO SHALL be RX_DEPTH x 34 bits; out_ack SHALL be !full, decoded from registered state only, with no path from rx_ready or in_req.
REQ-023 When full, a same-cycle pop SHALL NOT allow a push; out_ack SHALL rise on the following cycle.
REQ-024 rx_valid SHALL be !empty; rx_data, rx_head and rx_tail SHALL present the FIFO head entry; a pop SHALL occur on rx_valid && rx_ready.
REQ-025 Each accepted head flit with dst!=ID SHALL be acked, dropped with rx_err pulsed, and every flit up to and including its tail SHALL be dropped.
REQ-026 A non-head flit arriving outside a packet SHALL be acked, dropped and SHALL pulse rx_err.
REQ-027 rx_pkt_cnt SHALL increment when the tail of a kept packet is pushed.
REQ-028 Both counters SHALL wrap from 0xFFFF to 0.

Reset
REQ-029 Reset SHALL set the TX FSM to IDLE, empty the FIFO, clear the drop and in-packet flags, and zero both counters.
REQ-030 Output values in reset SHALL be: out_req=0, out_flit=0, rx_valid=0, rx_err=0, tx_ready=0, cmd_ready=1, out_ack=1.
REQ-031 Reset mid-packet SHALL abandon the packet with no tail sent; no recovery is required.

Structure
REQ-032 Package noc_pkg SHALL hold FLIT_W=34, HEAD_BIT=33, TAIL_BIT=32, SRC/DST/LEN field ranges and the TX state encoding, shared with the router.
REQ-033 The RX FIFO SHALL be a sub-module noc_fifo (parameters WIDTH, DEPTH) with push, pop, full, empty.

Verification
REQ-034 ID=5, cmd dst=9 len=0 with in_ack=1: out_flit=0x3_5900_0000 for one transfer, then out_req=0 and tx_pkt_cnt=1.
REQ-035 dst=2 len=3, words A,B,C, in_ack=1 continuously: flits 0x2_5200_0003, 0x0_A, 0x0_B, 0x1_C on consecutive cycles.
REQ-036 in_ack held at 0 for 10 cycles during BODY: out_flit is stable, tx_ready=0, and there is no loss or duplication.
REQ-037 rx_ready=0 with 5 flits offered and RX_DEPTH=4: out_ack=0 after the 4th push; after one pop, the 5th flit is accepted on the following cycle, and order is preserved.
REQ-038 Head with dst=7 at ID=5, 2 body flits and a tail: all acked, none pushed, rx_err=1 for one cycle, rx_pkt_cnt unchanged.
REQ-039 rst asserted mid-BODY: out_req=0 and cmd_ready=1 immediately, without waiting for a clk edge.
